// File: rtl/clock_disp_pkg.sv
// rtl/clock_disp_pkg.sv - shared types and segment constants for the clock display scanner
package clock_disp_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [6:0] seg_t;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam seg_t SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  localparam seg_t SEG_DASH = 7'h3F;
  localparam seg_t SEG_DARK = 7'h7F;

  typedef struct packed {
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    logic       ampm;
  } time_snap_t;

  function automatic logic [NUM_DIGITS-1:0] digit_enable(input logic [2:0] idx);
    return ~(6'b1 << idx);
  endfunction

endpackage

// File: rtl/clock_display_scan_if.sv
// rtl/clock_display_scan_if.sv - time inputs and display pins of the scanner
interface clock_display_scan_if;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hr;
  logic       ampm;
  logic       blank;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp;

  modport master (output sec, min, hr, ampm, blank, input seg, an, dp);
  modport slave  (input sec, min, hr, ampm, blank, output seg, an, dp);
endinterface

// File: rtl/seg7_encode.sv
// rtl/seg7_encode.sv - one digit value to active-low seven-segment pattern
module seg7_encode
  import clock_disp_pkg::*;
(
  input  logic [3:0] value,
  input  logic       dash,
  input  logic       dark,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_DASH;
    if (dark)
      seg = SEG_DARK;
    else if (!dash && value <= 4'd9)
      seg = SEG_DIGIT[value];
  end

endmodule

// File: rtl/clock_display_scan.sv
// rtl/clock_display_scan.sv - 6-digit multiplexed display driver with per-frame time snapshot
module clock_display_scan
  import clock_disp_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  clock_display_scan_if.slave   disp
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [2:0]    digit_idx;
  logic [2:0]    next_idx;
  time_snap_t    snap;
  time_snap_t    next_snap;
  logic          tick;
  logic          frame_wrap;
  logic          blank_q;
  seg_t          seg_q;
  logic [5:0]    an_q;
  logic          dp_q;

  assign tick       = (prescaler == PRE_LAST);
  assign frame_wrap = tick && (digit_idx == 3'd5);
  assign next_idx   = !tick ? digit_idx : (frame_wrap ? 3'd0 : digit_idx + 3'd1);

  // The frame's first digit is drawn from the values captured on the same edge
  always_comb begin
    next_snap = snap;
    if (frame_wrap) begin
      next_snap.sec  = disp.sec;
      next_snap.min  = disp.min;
      next_snap.hr   = disp.hr;
      next_snap.ampm = disp.ampm;
    end
  end

  logic [3:0] sec_tens, sec_ones, min_tens, min_ones, hr_tens, hr_ones;
  logic       sec_bad, min_bad, hr_bad;

  assign sec_tens = 4'(next_snap.sec / 6'd10);
  assign sec_ones = 4'(next_snap.sec % 6'd10);
  assign min_tens = 4'(next_snap.min / 6'd10);
  assign min_ones = 4'(next_snap.min % 6'd10);
  assign hr_tens  = 4'(next_snap.hr / 5'd10);
  assign hr_ones  = 4'(next_snap.hr % 5'd10);
  assign sec_bad  = next_snap.sec > 6'd59;
  assign min_bad  = next_snap.min > 6'd59;
  assign hr_bad   = (next_snap.hr == 5'd0) || (next_snap.hr > 5'd12);

  logic [3:0] sel_value;
  logic       sel_dash;
  logic       sel_dark;
  seg_t       enc_seg;

  always_comb begin
    sel_value = 4'd0;
    sel_dash  = 1'b0;
    sel_dark  = 1'b0;
    case (next_idx)
      3'd0: begin sel_value = sec_ones; sel_dash = sec_bad; end
      3'd1: begin sel_value = sec_tens; sel_dash = sec_bad; end
      3'd2: begin sel_value = min_ones; sel_dash = min_bad; end
      3'd3: begin sel_value = min_tens; sel_dash = min_bad; end
      3'd4: begin sel_value = hr_ones;  sel_dash = hr_bad;  end
      default: begin
        sel_value = hr_tens;
        sel_dash  = hr_bad;
        sel_dark  = !hr_bad && (next_snap.hr < 5'd10);
      end
    endcase
  end

  seg7_encode u_encode (
    .value (sel_value),
    .dash  (sel_dash),
    .dark  (sel_dark),
    .seg   (enc_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      digit_idx <= 3'd5;
      snap      <= '0;
      blank_q   <= 1'b0;
      seg_q     <= SEG_DARK;
      an_q      <= 6'h3F;
      dp_q      <= 1'b1;
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      digit_idx <= next_idx;
      snap      <= next_snap;
      blank_q   <= disp.blank;
      if (tick)
        seg_q <= enc_seg;
      // blank_q restores the anode right after a blank release, without waiting for a tick
      if (disp.blank) begin
        an_q <= 6'h3F;
        dp_q <= 1'b1;
      end else if (tick || blank_q) begin
        an_q <= digit_enable(next_idx);
        dp_q <= !((next_idx == 3'd0) && next_snap.ampm);
      end
    end
  end

  assign disp.seg = seg_q;
  assign disp.an  = an_q;
  assign disp.dp  = dp_q;

endmodule

// File: doc/clock_display_scan.md
Name: clock_display_scan

Overview:
- Consumer side of the CLOCK time outputs. Reads the binary sec/min/hr/AM-PM values and drives a 6-digit, common-anode, time-multiplexed seven-segment display.
- Takes one coherent snapshot of the time per scan frame, so a rollover mid-frame cannot tear the display.
- Sits between the CLOCK core and the board display pins.

Parameters:
- CLK_DIV, 50000, clk cycles per digit dwell; legal range >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- sec  input  6  seconds, binary, legal 0..59
- min  input  6  minutes, binary, legal 0..59
- hr  input  5  hours, binary, 12-hour format, legal 1..12
- ampm  input  1  0=AM, 1=PM
- blank  input  1  1 = all digits dark; scanning continues
- seg  output  7  segments, active-low, bit order {g,f,e,d,c,b,a}
- an  output  6  digit enables, active-low, an[0]=rightmost digit
- dp  output  1  decimal point, active-low

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values (applied immediately on rst, asynchronously):
  - Outputs: seg=7'h7F, an=6'h3F, dp=1.
  - Internal: prescaler=0, digit_idx=5, snapshot={sec 0, min 0, hr 0, ampm 0}.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick=1 on the cycle the count equals CLK_DIV-1.
  - First tick occurs CLK_DIV cycles after rst deasserts.
- Digit index: on tick, digit_idx <= (digit_idx==5) ? 0 : digit_idx+1.
- Snapshot: on a tick where digit_idx moves 5->0, live sec/min/hr/ampm are captured. The digit shown for idx 0 on that same edge uses the newly captured values.
- Digit map:
  - idx0 = sec ones, idx1 = sec tens
  - idx2 = min ones, idx3 = min tens
  - idx4 = hr ones, idx5 = hr tens
- Output registers:
  - Loaded only on tick, from the new digit_idx and snapshot; held between ticks.
  - Output latency is the same edge as the index change.
  - an = ~(1<<idx) when blank=0.
- BCD conversion: tens = v/10, ones = v%10, computed combinationally from the snapshot (max value 59).
- Encoding (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - dash=3F, dark=7F
- Field validation:
  - sec>59 or min>59 -> both digits of that field show dash.
  - hr==0 or hr>12 -> both hour digits show dash.
- Leading zero: valid hr<10 -> hour tens digit shows dark (seg=7F) while its anode is still driven.
- dp: 0 only when idx==0 and snapshot ampm==1; otherwise 1. Forced to 1 for dash fields? No — dp follows ampm regardless of validity.
- blank:
  - Sampled every cycle, not just on tick.
  - blank=1 -> an=3F and dp=1 at the next edge.
  - Prescaler, digit_idx and snapshot keep running.
  - On deassert, an resumes for the current idx at the next edge.
- Reset mid-frame: everything returns to reset values; no partial frame is kept.
- Input changes between frame boundaries have no effect on the display until the next 5->0 transition.

Decomposition:
- Package clock_disp_pkg:
  - NUM_DIGITS=6
  - typedef seg_t (logic [6:0])
  - constants SEG_DIGIT[0:9], SEG_DASH, SEG_DARK
  - typedef time_snap_t struct {sec, min, hr, ampm}
- Sub-module seg7_encode:
  - inputs: 4-bit value plus dash and dark flags
  - output: seg_t
  - purely combinational, instantiated once on the selected digit.

Test Plan:
- Reset/start-up (CLK_DIV=4):
  - Hold rst -> seg=7F, an=3F, dp=1, including when rst is asserted between clk edges.
  - Release rst -> 4th rising edge gives an=3E.
- Full frame at 12:34:56 PM:
  - Each tick gives an sequence 3E,3D,3B,37,2F,1F.
  - Matching seg 02,12,19,30,24,79.
  - dp=0 only with an=3E.
- Boundaries:
  - hr=9, min=5, sec=0 -> hour tens seg=7F, min tens seg=40, sec seg=40,40.
  - hr=0 -> hour digits both 3F.
  - hr=13 -> hour digits both 3F.
  - sec=60 -> sec digits both 3F.
- Coherence:
  - Start frame at 12:59:59. At idx3, change inputs to 01:00:00 AM.
  - Remainder of frame shows 5,2,1 for idx3..5.
  - Next frame shows 0,0,0,0,1,dark with dp=1.
- blank:
  - Assert at idx2 for 10 cycles -> an=3F next edge; ticks continue.
  - On release, an matches the current idx, with no frame restart.
- Async reset mid-frame at idx3 -> immediate seg=7F/an=3F.
  - After release, the first tick gives idx0 with a new snapshot.
